// File: rtl/jtvigil_sndcmd.sv
// Main-CPU side of the sound command link: queues command bytes in a small FIFO
// and hands them to the sound latch one at a time, waiting for the sound CPU's ack.
module jtvigil_sndcmd #(
  parameter int          AW      = 3,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       main_wr,
  input  logic [7:0] main_dout,
  input  logic       flush,
  input  logic       snd_ack,
  output logic [7:0] snd_latch,
  output logic       latch_wr,
  output logic       busy,
  output logic       full,
  output logic [7:0] status
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   timer;
  logic [3:0]    level;
  logic          wr_l, ovf, tout;
  logic          push_edge, pop, push_ok;

  always_comb begin
    push_edge = main_wr & ~wr_l;
    pop       = (state == SEND);
    // count never exceeds DEPTH, so its MSB alone marks a full FIFO
    full      = count[AW];
    push_ok   = push_edge && (!full || pop);
    busy      = (count != '0) || (state != IDLE);
    status    = {ovf, tout, 2'b00, level};
  end

  if (AW >= 3) begin : g_lvl_wide
    assign level = count[3:0];
  end else begin : g_lvl_narrow
    assign level = {{(3 - AW){1'b0}}, count};
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= main_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      timer     <= '0;
      wr_l      <= 1'b0;
      ovf       <= 1'b0;
      tout      <= 1'b0;
      snd_latch <= '0;
      latch_wr  <= 1'b0;
    end else begin
      wr_l <= main_wr;
      if (flush) begin
        // abort everything in flight; snd_latch intentionally keeps its last byte
        state    <= IDLE;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        timer    <= '0;
        ovf      <= 1'b0;
        tout     <= 1'b0;
        latch_wr <= 1'b0;
      end else begin
        latch_wr <= 1'b0;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (push_edge && !push_ok) ovf <= 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (!push_ok && pop) count <= count - 1'b1;

        case (state)
          IDLE: begin
            if (count != '0) begin
              state     <= SEND;
              latch_wr  <= 1'b1;
              snd_latch <= mem[rd_ptr];
            end
          end
          SEND: begin
            timer <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (snd_ack) begin
              state <= IDLE;
            end else if (cen) begin
              if (timer == TIMEOUT - 16'd1) begin
                tout  <= 1'b1;
                state <= IDLE;
              end else begin
                timer <= timer + 16'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtvigil_sndcmd.sv
// Directed bench for jtvigil_sndcmd: scoreboard of expected latch bytes plus status checks.
module tb_jtvigil_sndcmd;

  logic       clk = 1'b0;
  logic       rst, cen, main_wr, flush, snd_ack;
  logic [7:0] main_dout, snd_latch, status;
  logic       latch_wr, busy, full;

  int checks  = 0;
  int passes  = 0;
  int strobes = 0;
  logic [7:0] exp_q[$];

  jtvigil_sndcmd #(.AW(3), .TIMEOUT(16'd8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .main_wr   (main_wr),
    .main_dout (main_dout),
    .flush     (flush),
    .snd_ack   (snd_ack),
    .snd_latch (snd_latch),
    .latch_wr  (latch_wr),
    .busy      (busy),
    .full      (full),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit acc);
    main_dout = b;
    main_wr   = 1'b1;
    if (acc) exp_q.push_back(b);
    cyc;
    main_wr = 1'b0;
    cyc;
  endtask

  task automatic wait_strobe(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc;
      if (latch_wr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 16'(ok), 16'd1);
  endtask

  task automatic ack;
    snd_ack = 1'b1;
    cyc;
    snd_ack = 1'b0;
  endtask

  // scoreboard: every latch strobe must deliver the oldest expected byte
  always @(negedge clk) begin
    if (latch_wr === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) chk("unexpected_strobe", {8'h00, snd_latch}, 16'h0100);
      else chk("strobe_data", 16'(snd_latch), 16'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1; cen = 1'b0; main_wr = 1'b0; main_dout = '0; flush = 1'b0; snd_ack = 1'b0;
    repeat (3) cyc;
    chk("rst_latch",    16'(snd_latch), 16'h0);
    chk("rst_latch_wr", 16'(latch_wr),  16'h0);
    chk("rst_status",   16'(status),    16'h0);
    chk("rst_busy",     16'(busy),      16'h0);
    chk("rst_full",     16'(full),      16'h0);
    rst = 1'b0;
    cyc;

    // single byte: strobe exactly two clocks after the push edge
    main_dout = 8'h5A; main_wr = 1'b1; exp_q.push_back(8'h5A);
    cyc;
    main_wr = 1'b0;
    chk("t1_no_strobe_yet", 16'(latch_wr), 16'h0);
    chk("t1_level1",        16'(status),   16'h01);
    cyc;
    chk("t1_strobe",    16'(latch_wr),  16'h1);
    chk("t1_latch",     16'(snd_latch), 16'h5A);
    cyc;
    chk("t1_strobe_1clk", 16'(latch_wr), 16'h0);
    chk("t1_busy",        16'(busy),     16'h1);

    // held write while waiting for ack: one entry only, no new strobe
    main_dout = 8'h11; main_wr = 1'b1; exp_q.push_back(8'h11);
    repeat (5) cyc;
    main_wr = 1'b0;
    cyc;
    chk("t2_level1",   16'(status),  16'h01);
    chk("t2_busy",     16'(busy),    16'h1);
    chk("t2_strobes",  16'(strobes), 16'd1);
    ack;
    wait_strobe("t2_send");
    cyc;
    ack;
    chk("t2_idle_busy", 16'(busy),   16'h0);
    chk("t2_idle_stat", 16'(status), 16'h00);

    // fill: first byte in flight, eight queued, tenth overflows
    for (int i = 1; i <= 9; i++) push(8'(i), 1'b1);
    chk("t3_level8", 16'(status), 16'h08);
    chk("t3_full",   16'(full),   16'h1);
    push(8'h0A, 1'b0);
    chk("t3_ovf", 16'(status), 16'h88);
    ack;
    wait_strobe("t3_first_ack");
    // push lands on the pop clock of a full FIFO: must be accepted
    main_dout = 8'h0B; main_wr = 1'b1; exp_q.push_back(8'h0B);
    cyc;
    main_wr = 1'b0;
    chk("t3_push_on_pop", 16'(status), 16'h88);
    for (int i = 0; i < 8; i++) begin
      cyc;
      ack;
      wait_strobe("t3_drain");
    end
    cyc;
    chk("t3_ovf_sticky", 16'(status), 16'h80);
    chk("t3_wait_busy",  16'(busy),   16'h1);
    flush = 1'b1;
    cyc;
    flush = 1'b0;
    chk("t3_flush_stat", 16'(status), 16'h00);
    chk("t3_flush_busy", 16'(busy),   16'h0);

    // flush in WAIT with three queued; simultaneous push is dropped
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i), 1'b1);
    chk("t6_level3", 16'(status), 16'h03);
    flush = 1'b1; main_wr = 1'b1; main_dout = 8'h77;
    cyc;
    flush = 1'b0; main_wr = 1'b0;
    exp_q.delete();
    chk("t6_status",   16'(status),    16'h00);
    chk("t6_busy",     16'(busy),      16'h0);
    chk("t6_latch",    16'(snd_latch), 16'h21);
    chk("t6_latch_wr", 16'(latch_wr),  16'h0);
    s0 = strobes;
    repeat (6) cyc;
    chk("t6_no_strobe", 16'(strobes - s0), 16'd0);
    chk("t6_still_empty", 16'(status), 16'h00);

    // timeout after eight cen ticks in WAIT, then next byte goes out
    cen = 1'b1;
    main_dout = 8'h31; main_wr = 1'b1; exp_q.push_back(8'h31);
    cyc;
    main_wr = 1'b0;
    wait_strobe("t4_first");
    main_dout = 8'h32; main_wr = 1'b1; exp_q.push_back(8'h32);
    cyc;
    main_wr = 1'b0;
    repeat (7) cyc;
    chk("t4_tout_early", 16'(status[6]), 16'h0);
    cyc;
    chk("t4_tout_set", 16'(status), 16'h41);
    wait_strobe("t4_next");
    flush = 1'b1;
    cyc;
    flush = 1'b0;
    chk("t4_flush_clear", 16'(status), 16'h00);

    // ack on the expiry clock wins
    main_dout = 8'h41; main_wr = 1'b1; exp_q.push_back(8'h41);
    cyc;
    main_wr = 1'b0;
    wait_strobe("t5_send");
    repeat (8) cyc;
    ack;
    chk("t5_no_tout", 16'(status), 16'h00);
    chk("t5_idle",    16'(busy),   16'h0);

    // reset during WAIT
    main_dout = 8'h51; main_wr = 1'b1; exp_q.push_back(8'h51);
    cyc;
    main_wr = 1'b0;
    wait_strobe("t7_send");
    cyc;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    exp_q.delete();
    chk("t7_latch",  16'(snd_latch), 16'h00);
    chk("t7_status", 16'(status),    16'h00);
    chk("t7_busy",   16'(busy),      16'h0);
    s0 = strobes;
    repeat (15) cyc;
    chk("t7_no_strobe", 16'(strobes - s0), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
